// File: rtl/cacheline_adaptor_if.sv
// rtl/cacheline_adaptor_if.sv - cache line port and memory burst bus bundle
//
// Purpose: groups the cache-side line port and the memory-side burst bus of
// the cache line adaptor into one bundle.
// Ports (adaptor view, modport slave):
//   line_i/line_o       256-bit writeback line in / assembled read line out
//   address_i           cache line address in
//   read_i/write_i      cache line read / writeback requests (level)
//   resp_o              one-cycle transaction complete pulse to the cache
//   burst_i/burst_o     64-bit read beat in / write beat out
//   address_o           line-aligned memory address
//   read_o/write_o      memory read / write requests
//   resp_i              memory beat strobe
// The master modport is the environment's view (cache controller + memory).
interface cacheline_adaptor_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
);
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit cache line to 4x64-bit memory burst adaptor
//
// Purpose: turns one cache line read or writeback into a 4-beat burst on the
// memory bus and returns the line (or a write acknowledge) with a one-cycle
// resp_o pulse.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   cacheline_adaptor_if.slave (cache line port + memory burst bus)
module cacheline_adaptor #(
  parameter int s_line    = 256,
  parameter int s_burst   = 64,
  parameter int s_offset  = 5,
  parameter int burst_len = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cacheline_adaptor_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [31:0] offset_mask = 32'((64'd1 << s_offset) - 64'd1);

  state_t              state_q;
  logic [1:0]          count_q;
  logic [1:0]          count_d;
  logic                last_beat;
  logic [s_line-1:0]   rbuf_q;
  logic [s_line-1:0]   wbuf_q;
  logic [31:0]         addr_q;
  logic                read_q;
  logic                write_q;
  logic                resp_q;

  // The counter only ever increments; it wraps 3->0 on the final beat, so it
  // is already zero when the next transaction starts.
  always_comb begin
    count_d   = count_q + 2'd1;
    last_beat = (count_q == 2'(burst_len - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= 2'd0;
      rbuf_q  <= '0;
      wbuf_q  <= '0;
      addr_q  <= 32'd0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Read has priority over a simultaneous writeback request.
          if (bus.read_i) begin
            addr_q  <= bus.address_i & ~offset_mask;
            count_q <= 2'd0;
            read_q  <= 1'b1;
            state_q <= READ;
          end else if (bus.write_i) begin
            addr_q  <= bus.address_i & ~offset_mask;
            count_q <= 2'd0;
            wbuf_q  <= bus.line_i;
            write_q <= 1'b1;
            state_q <= WRITE;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            rbuf_q[int'(count_q)*s_burst +: s_burst] <= bus.burst_i;
            count_q <= count_d;
            if (last_beat) begin
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            count_q <= count_d;
            if (last_beat) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The write beat is selected straight from the registered count, so it only
  // changes on an edge that consumed a strobe.
  assign bus.burst_o   = wbuf_q[int'(count_q)*s_burst +: s_burst];
  assign bus.line_o    = rbuf_q;
  assign bus.address_o = addr_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [255:0] model_line = '0;  // expected line_o contents

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [31:0] line_addr(input logic [31:0] a);
    return (a / 32) * 32;
  endfunction

  function automatic logic [63:0] beat_of(input logic [255:0] l, input int k);
    return l[k*64 +: 64];
  endfunction

  task automatic check_ctl(input string name, input logic rd, input logic wr, input logic rs);
    // Observes the three control outputs together as one comparison.
    checks++;
    if ({bus.read_o, bus.write_o, bus.resp_o} !== {rd, wr, rs}) begin
      errors++;
      $display("FAIL %s: read_o,write_o,resp_o got %b%b%b expected %b%b%b",
               name, bus.read_o, bus.write_o, bus.resp_o, rd, wr, rs);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.read_i = 0; bus.write_i = 0; bus.resp_i = 0;
    bus.address_i = '0; bus.line_i = '0; bus.burst_i = '0;
    @(negedge clk);
    checks++;
    if ({bus.line_o, bus.burst_o, bus.address_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: line/burst/address not zero line=%h burst=%h addr=%h",
               bus.line_o, bus.burst_o, bus.address_o);
    end
    check_ctl("reset_ctl", 0, 0, 0);
    step;
    rst = 1'b0;
    step;
    check_ctl("post_reset_idle", 0, 0, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input int gap[4],
                         input bit with_write, input bit keep, input string name);
    bus.read_i = 1; bus.write_i = with_write; bus.address_i = addr; bus.line_i = rand_line();
    step;
    check_ctl({name, "_accept"}, 1, 0, 0);
    checks++;
    if (bus.address_o !== line_addr(addr)) begin
      errors++;
      $display("FAIL %s_addr: address_o got %h expected %h", name, bus.address_o, line_addr(addr));
    end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap[k]; g++) begin
        bus.resp_i = 0; bus.burst_i = {$urandom, $urandom};
        step;
        check_ctl({name, "_gap"}, 1, 0, 0);
      end
      bus.resp_i = 1; bus.burst_i = beat_of(line, k);
      step;
      bus.resp_i = 0;
      if (k < 3) check_ctl({name, "_beat"}, 1, 0, 0);
    end
    check_ctl({name, "_done"}, 0, 0, 1);
    model_line = line;
    checks++;
    if (bus.line_o !== model_line) begin
      errors++;
      $display("FAIL %s_line: line_o got %h expected %h", name, bus.line_o, model_line);
    end
    if (!keep) begin
      bus.read_i = 0; bus.write_i = 0;
      step;
      check_ctl({name, "_after"}, 0, 0, 0);
      checks++;
      if (bus.line_o !== model_line) begin
        errors++;
        $display("FAIL %s_hold: line_o got %h expected %h", name, bus.line_o, model_line);
      end
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int gap[4],
                          input bit corrupt, input string name);
    bus.write_i = 1; bus.read_i = 0; bus.address_i = addr; bus.line_i = line;
    step;
    check_ctl({name, "_accept"}, 0, 1, 0);
    checks++;
    if (bus.address_o !== line_addr(addr)) begin
      errors++;
      $display("FAIL %s_addr: address_o got %h expected %h", name, bus.address_o, line_addr(addr));
    end
    if (corrupt) bus.line_i = ~line;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap[k]; g++) begin
        bus.resp_i = 0;
        step;
        check_ctl({name, "_gap"}, 0, 1, 0);
      end
      bus.resp_i = 1;
      checks++;
      if (bus.burst_o !== beat_of(line, k)) begin
        errors++;
        $display("FAIL %s_burst%0d: burst_o got %h expected %h", name, k, bus.burst_o, beat_of(line, k));
      end
      step;
      bus.resp_i = 0;
      if (k < 3) check_ctl({name, "_beat"}, 0, 1, 0);
    end
    check_ctl({name, "_done"}, 0, 0, 1);
    checks++;
    if (bus.line_o !== model_line) begin
      errors++;
      $display("FAIL %s_line: line_o got %h expected %h", name, bus.line_o, model_line);
    end
    bus.write_i = 0;
    step;
    check_ctl({name, "_after"}, 0, 0, 0);
  endtask

  task automatic test_read_consecutive;
    int g[4];
    logic [255:0] l;
    g = '{0, 0, 0, 0};
    l = {64'hCAFE_0000_0000_00A3, 64'hCAFE_0000_0000_00A2,
         64'hCAFE_0000_0000_00A1, 64'hCAFE_0000_0000_00A0};
    do_read(32'h1234_5678, l, g, 0, 0, "read_consec");
    checks++;
    if (bus.address_o !== 32'h1234_5660) begin
      errors++;
      $display("FAIL read_consec_addr_const: address_o got %h expected 12345660", bus.address_o);
    end
  endtask

  task automatic test_read_gaps;
    int g[4];
    g = '{0, 2, 0, 1};
    do_read($urandom, rand_line(), g, 0, 0, "read_gaps");
  endtask

  task automatic test_write;
    int g[4];
    g = '{1, 0, 2, 0};
    do_write($urandom, rand_line(), g, 1, "write");
  endtask

  task automatic test_simultaneous;
    int g[4];
    g = '{0, 1, 0, 0};
    do_read($urandom, rand_line(), g, 1, 0, "both_req");
  endtask

  task automatic test_reset_mid_read;
    int g[4];
    g = '{0, 0, 0, 0};
    bus.read_i = 1; bus.address_i = $urandom;
    step;
    for (int k = 0; k < 2; k++) begin
      bus.resp_i = 1; bus.burst_i = {$urandom, $urandom};
      step;
    end
    bus.resp_i = 0;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.line_o, bus.burst_o, bus.address_o} !== '0) begin
      errors++;
      $display("FAIL midreset_data: line=%h burst=%h addr=%h expected all zero",
               bus.line_o, bus.burst_o, bus.address_o);
    end
    check_ctl("midreset_ctl", 0, 0, 0);
    bus.read_i = 0;
    model_line = '0;
    step;
    step;
    rst = 1'b0;
    step;
    check_ctl("midreset_release", 0, 0, 0);
    do_read($urandom, rand_line(), g, 0, 0, "read_after_reset");
  endtask

  task automatic test_back_to_back;
    int g[4];
    logic [31:0] a1;
    g = '{0, 0, 1, 0};
    bus.read_i = 0; bus.write_i = 0;
    for (int i = 0; i < 3; i++) begin
      bus.resp_i = 1; bus.burst_i = {$urandom, $urandom};
      step;
      check_ctl("idle_strobe", 0, 0, 0);
      checks++;
      if (bus.line_o !== model_line) begin
        errors++;
        $display("FAIL idle_strobe_line: line_o got %h expected %h", bus.line_o, model_line);
      end
    end
    bus.resp_i = 0;
    a1 = $urandom;
    do_read(a1, rand_line(), g, 0, 1, "b2b_first");
    bus.address_i = $urandom;
    step;
    check_ctl("b2b_idle_gap", 0, 0, 0);
    checks++;
    if (bus.address_o !== line_addr(a1)) begin
      errors++;
      $display("FAIL b2b_addr_held: address_o got %h expected %h", bus.address_o, line_addr(a1));
    end
    do_read($urandom, rand_line(), g, 0, 0, "b2b_second");
  endtask

  task automatic test_random;
    int g[4];
    for (int it = 0; it < 16; it++) begin
      for (int k = 0; k < 4; k++) g[k] = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0)
        do_read($urandom, rand_line(), g, $urandom_range(0, 1), 0, "rand_read");
      else
        do_write($urandom, rand_line(), g, $urandom_range(0, 1), "rand_write");
    end
  endtask

  initial begin
    test_reset;
    test_read_consecutive;
    test_read_gaps;
    test_write;
    test_simultaneous;
    test_reset_mid_read;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
